// File: rtl/rr_mux_pkg.sv
// Shared constants for the registered round-robin multiplexer.
// Mode encodings are used by both the arbiter and its users.
package mux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CH    = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_mux_if.sv
// Channel-side and consumer-side handshake bundle for rr_mux.
// master = producers/consumer environment, slave = the mux itself.
interface rr_mux_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);
    localparam int SELW = $clog2(CH);

    logic [CH*WIDTH-1:0] Din;
    logic [CH-1:0]       Din_valid;
    logic [CH-1:0]       Din_ready;
    logic [WIDTH-1:0]    Dout;
    logic                Dout_valid;
    logic                Dout_ready;
    logic [SELW-1:0]     Dout_ch;

    modport master (
        output Din, Din_valid, Dout_ready,
        input  Din_ready, Dout, Dout_valid, Dout_ch
    );

    modport slave (
        input  Din, Din_valid, Dout_ready,
        output Din_ready, Dout, Dout_valid, Dout_ch
    );

endinterface

// File: rtl/rr_mux_arbiter.sv
// Combinational grant logic: fixed select or round-robin starting after 'last'.
// No grant is ever produced for an out-of-range Sel.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CH   = DEF_CH,
    localparam int SELW = $clog2(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] last,
    input  logic            Mode,
    input  logic [SELW-1:0] Sel,
    output logic            grant_vld,
    output logic [SELW-1:0] grant_idx
);

    int rr_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (Mode == MODE_FIXED) begin
            // Compare against every legal index so Sel >= CH simply never matches
            for (int k = 0; k < CH; k++) begin
                if (int'(Sel) == k && req[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
        end else begin
            // Scan farthest-first so the nearest requester after 'last' wins
            for (int i = CH; i >= 1; i--) begin
                rr_idx = (int'(last) + i) % CH;
                if (req[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(rr_idx);
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel registered mux with valid/ready on every side; fixed or round-robin
// channel choice, one output register stage, and source-channel tagging.
module rr_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int CH    = DEF_CH,
    localparam int SELW  = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Mode,
    input  logic [SELW-1:0] Sel,
    rr_mux_if.slave         bus
);

    logic [SELW-1:0]  last;
    logic             grant_vld;
    logic [SELW-1:0]  g;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] din_sel;

    rr_arbiter #(.CH(CH)) u_arb (
        .req       (bus.Din_valid),
        .last      (last),
        .Mode      (Mode),
        .Sel       (Sel),
        .grant_vld (grant_vld),
        .grant_idx (g)
    );

    // Refill whenever the register is empty or being drained this cycle
    assign load = !bus.Dout_valid || bus.Dout_ready;
    assign xfer = rst_n && load && grant_vld;

    always_comb begin
        bus.Din_ready = '0;
        din_sel       = '0;
        for (int k = 0; k < CH; k++) begin
            if (SELW'(k) == g) begin
                bus.Din_ready[k] = xfer;
                din_sel          = bus.Din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Dout       <= '0;
            bus.Dout_valid <= 1'b0;
            bus.Dout_ch    <= '0;
            last           <= SELW'(CH - 1);
        end else if (xfer) begin
            bus.Dout       <= din_sel;
            bus.Dout_ch    <= g;
            bus.Dout_valid <= 1'b1;
            last           <= g;
        end else if (bus.Dout_ready) begin
            bus.Dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (WIDTH=8, CH=4): reset, fixed select, round-robin,
// sparse wrap, back-pressure and mid-run reset, with hand-computed expectations.
module tb_rr_mux;
    import mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    int         n_cmp = 0;
    int         n_err = 0;

    rr_mux_if #(.WIDTH(8), .CH(4)) bus ();

    rr_mux #(.WIDTH(8), .CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Mode  (mode),
        .Sel   (sel),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic v);
        chk({tag, "_dout"}, 32'(bus.Dout), 32'(d));
        chk({tag, "_ch"},   32'(bus.Dout_ch), 32'(ch));
        chk({tag, "_vld"},  32'(bus.Dout_valid), 32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        mode           = MODE_RR;
        sel            = 2'd0;
        bus.Din_valid  = 4'b1111;
        bus.Dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) bus.Din[k*8 +: 8] = 8'h10 + 8'(k);

        // Reset held for two edges with every channel requesting
        settle();
        chk("rst_rdy0", 32'(bus.Din_ready), 32'h0);
        tick();
        chk_out("rst1", 8'h00, 2'd0, 1'b0);
        chk("rst_rdy1", 32'(bus.Din_ready), 32'h0);
        tick();
        chk_out("rst2", 8'h00, 2'd0, 1'b0);

        // Release: fair rotation 0,1,2,3,0,1,2,3
        rst_n          = 1'b1;
        bus.Dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("rr_rdy", 32'(bus.Din_ready), 32'(1 << (i % 4)));
            tick();
            chk_out("rr", 8'h10 + 8'(i % 4), 2'(i % 4), 1'b1);
        end

        // Sparse requests from last=3: 1, 3, 1 and channel 0 never granted
        bus.Din_valid = 4'b1010;
        settle();
        chk("sp_rdy1", 32'(bus.Din_ready), 32'b0010);
        tick();
        chk_out("sp1", 8'h11, 2'd1, 1'b1);
        settle();
        chk("sp_rdy3", 32'(bus.Din_ready), 32'b1000);
        tick();
        chk_out("sp3", 8'h13, 2'd3, 1'b1);
        settle();
        chk("sp_rdy1b", 32'(bus.Din_ready), 32'b0010);
        tick();
        chk_out("sp1b", 8'h11, 2'd1, 1'b1);

        // Fixed select of channel 2
        mode             = MODE_FIXED;
        sel              = 2'd2;
        bus.Din[16 +: 8] = 8'hA5;
        bus.Din_valid    = 4'b0100;
        settle();
        chk("fx_rdy", 32'(bus.Din_ready), 32'b0100);
        tick();
        chk_out("fx", 8'hA5, 2'd2, 1'b1);

        // Selected channel idle: no ready, register drains, data/channel hold
        sel = 2'd1;
        settle();
        chk("fx_idle_rdy", 32'(bus.Din_ready), 32'h0);
        tick();
        chk_out("fx_drain", 8'hA5, 2'd2, 1'b0);

        // Fill with 5A from channel 2, then stall for three cycles
        sel              = 2'd2;
        bus.Din[16 +: 8] = 8'h5A;
        tick();
        chk_out("bp_fill", 8'h5A, 2'd2, 1'b1);
        bus.Dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode          = (i % 2 == 0) ? MODE_RR : MODE_FIXED;
            bus.Din_valid = 4'(4'b1111 >> i);
            bus.Din[24 +: 8] = 8'h30 + 8'(i);
            settle();
            chk("bp_rdy", 32'(bus.Din_ready), 32'h0);
            tick();
            chk_out("bp_hold", 8'h5A, 2'd2, 1'b1);
        end

        // Release: drain and reload on one edge; last=2 so channel 3 is next
        mode             = MODE_RR;
        bus.Din_valid    = 4'b1111;
        bus.Din[24 +: 8] = 8'h33;
        bus.Dout_ready   = 1'b1;
        settle();
        chk("bp_rel_rdy", 32'(bus.Din_ready), 32'b1000);
        tick();
        chk_out("bp_reload", 8'h33, 2'd3, 1'b1);
        settle();
        chk("bp_wrap_rdy", 32'(bus.Din_ready), 32'b0001);
        tick();
        chk_out("bp_wrap", 8'h10, 2'd0, 1'b1);

        // Stalled full register, then reset discards it
        bus.Dout_ready = 1'b0;
        settle();
        chk("mr_stall_rdy", 32'(bus.Din_ready), 32'h0);
        rst_n = 1'b0;
        settle();
        chk("mr_rst_rdy", 32'(bus.Din_ready), 32'h0);
        tick();
        chk_out("mr_rst", 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;
        settle();
        chk("mr_restart_rdy", 32'(bus.Din_ready), 32'b0001);
        tick();
        chk_out("mr_restart", 8'h10, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
